if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage that owns the program counter, issues requests to instruction memory over a ready-based handshake, and loads the 64-bit IF/ID pipeline register that the ID-stage decoder consumes. It absorbs memory wait states, a downstream stall (via a one-entry skid buffer), a flush, and jump/branch redirects from later stages. The IF/ID register layout is fixed: bits [63:32] hold the fetched instruction's address + 4, and bits [31:0] hold the instruction word.

## Interface
- RESET_PC, 32'h0000_0000, address of the first fetched instruction
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, word aligned
- imem_rdata  in  32  instruction word, valid in a cycle with imem_ready=1
- imem_ready  in  1  memory returns imem_rdata for imem_addr this cycle
- stall  in  1  ID stage cannot accept; hold IF/ID
- flush  in  1  replace IF/ID contents with a bubble
- redirect  in  1  taken jump/branch; refetch from redirect_pc
- redirect_pc  in  32  redirect target
- ifid_reg  out  64  {pc+4, instr}, registered
- ifid_valid  out  1  ifid_reg holds a real instruction
- pc  out  32  address of the next instruction not yet delivered to IF/ID

## Operation
- Reset values: pc=RESET_PC, state=FETCH, ifid_reg=0, ifid_valid=0, skid buffer empty. imem_req=0 while rst=1.
- imem_req=1 in FETCH and DROP, 0 in HOLD. imem_addr=pc in FETCH and HOLD, and the latched old address in DROP. imem_addr must stay stable until the handshake completes (imem_ready=1).
- Bubble: ifid_reg=64'h0 (decodes as sll $0 nop), ifid_valid=0.
- Per-cycle priority: redirect > flush > stall > normal.
- FETCH state:
  - ready & !stall: ifid_reg<={pc+4, imem_rdata}, ifid_valid<=1, pc<=pc+4.
  - !ready & !stall: load bubble.
  - ready & stall: ifid held, skid<=imem_rdata, go to HOLD, pc unchanged.
  - !ready & stall: everything held.
- HOLD state:
  - stall=1: everything held.
  - stall=0: ifid_reg<={pc+4, skid}, ifid_valid<=1, pc<=pc+4, go to FETCH.
- DROP state:
  - wait for imem_ready. The returned word is discarded.
  - Then go to FETCH with pc as already redirected.
  - ifid loads bubbles unless stall=1, in which case it holds.
- redirect=1, any state: pc<=redirect_pc, IF/ID<=bubble, skid discarded.
  - FETCH & !ready → DROP (the old address stays on imem_addr).
  - Otherwise → FETCH. A same-cycle response is discarded.
- flush=1 (no redirect): IF/ID<=bubble, skid discarded, pc not advanced.
  - A same-cycle response is discarded and the same pc is refetched.
  - HOLD → FETCH; DROP stays DROP.
- Arithmetic: pc+4 is modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0 with no error. redirect_pc[1:0] is ignored and forced to 00.

## Timing
- Zero-wait memory: request in cycle N → ifid_valid=1 with that instruction after edge N+1. Sustained throughput is 1 instruction/cycle.
- Each wait cycle adds one bubble to IF/ID.
- redirect in cycle N:
  - Target is requested in cycle N+1 (FETCH path), or the cycle after the old request's ready (DROP path).
  - Bubbles occupy IF/ID until the target arrives.
- HOLD release: instruction appears in IF/ID at the edge ending the first cycle with stall=0. The next request issues the following cycle.
- rst asserted mid-operation: all state returns to reset values immediately (asynchronous). Any outstanding memory response is ignored.

## Test plan
- Reset, RESET_PC=0, imem_ready tied 1, mem[i]=i+1:
  - Expect ifid_reg={32'h4, 32'h1}, then {8, 2}, {C, 3} on consecutive cycles.
  - ifid_valid=1 from the second edge on.
- imem_ready low 2 cycles on addr 8:
  - Expect two bubbles (ifid_reg=0, valid=0).
  - Then {32'hC, mem[8]}, with imem_addr held at 8 throughout.
- stall high 3 cycles, with the response for addr 4 arriving in the first stalled cycle:
  - ifid holds its prior value and imem_req=0 in HOLD.
  - After release, ifid={8, mem[4]} with no duplicate and no loss.
- redirect to 32'h100 while addr 0xC is waiting:
  - imem_addr stays 0xC until ready, and that data never appears in IF/ID.
  - Next request is 0x100, then ifid={32'h104, mem[0x100]}.
- Simultaneous redirect (0x40) + stall + flush with a response arriving:
  - Response is discarded, IF/ID becomes a bubble, pc=0x40.
- pc=32'hFFFF_FFFC fetch:
  - ifid[63:32]=0, next imem_addr=0.
- Assert rst during HOLD:
  - pc=RESET_PC, ifid=0, imem_req=0 immediately.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem request handshake and
// loads the {pc+4, instr} IF/ID pipeline register consumed by the decoder.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [63:0] ifid_reg,
  output logic        ifid_valid,
  output logic [31:0] pc
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc_n;
  logic [31:0] pc_inc;
  logic [31:0] skid, skid_n;
  logic [31:0] drop_addr, drop_addr_n;
  logic [63:0] ifid_n;
  logic        valid_n;

  assign pc_inc = pc + 32'd4;

  // Request is suppressed while the skid buffer holds a word, and during reset.
  assign imem_req  = !rst && (state != HOLD);
  assign imem_addr = (state == DROP) ? drop_addr : pc;

  // Next-state, PC and IF/ID selection; priority redirect > flush > stall.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    skid_n      = skid;
    drop_addr_n = drop_addr;
    ifid_n      = ifid_reg;
    valid_n     = ifid_valid;

    if (redirect) begin
      pc_n    = redirect_pc & 32'hFFFF_FFFC;
      ifid_n  = '0;
      valid_n = 1'b0;
      // An unfinished request must keep its address until ready arrives, so
      // it is converted into a drop of that same address.
      if (state != HOLD && !imem_ready) begin
        state_n     = DROP;
        drop_addr_n = imem_addr;
      end else begin
        state_n = FETCH;
      end
    end else if (flush) begin
      ifid_n  = '0;
      valid_n = 1'b0;
      if (state == DROP && !imem_ready) state_n = DROP;
      else                              state_n = FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (stall) begin
            if (imem_ready) begin
              skid_n  = imem_rdata;
              state_n = HOLD;
            end
          end else if (imem_ready) begin
            ifid_n  = {pc_inc, imem_rdata};
            valid_n = 1'b1;
            pc_n    = pc_inc;
          end else begin
            ifid_n  = '0;
            valid_n = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_n  = {pc_inc, skid};
            valid_n = 1'b1;
            pc_n    = pc_inc;
            state_n = FETCH;
          end
        end
        DROP: begin
          if (imem_ready) state_n = FETCH;
          if (!stall) begin
            ifid_n  = '0;
            valid_n = 1'b0;
          end
        end
        default: state_n = FETCH;
      endcase
    end
  end

  // State, PC, skid and IF/ID registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      skid       <= '0;
      drop_addr  <= '0;
      ifid_reg   <= '0;
      ifid_valid <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      skid       <= skid_n;
      drop_addr  <= drop_addr_n;
      ifid_reg   <= ifid_n;
      ifid_valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, reset-in-HOLD sequence and
// a randomized run against a transaction-level reference model.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall, flush, redirect;
  logic [31:0] redirect_pc;
  logic [63:0] ifid_reg;
  logic        ifid_valid;
  logic [31:0] pc;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .ifid_reg(ifid_reg), .ifid_valid(ifid_valid), .pc(pc)
  );

  always #5 clk = ~clk;

  // Memory image: word at byte address a holds (a/4)+1.
  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a >> 2) + 32'd1;
  endfunction

  assign imem_rdata = memword(imem_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic        st, fl, rd;
    logic [31:0] rpc;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic [63:0] ifid;
    logic        val;
    logic [31:0] pc;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic st, input logic fl, input logic rd, input logic [31:0] rpc,
                     input logic rdy, input logic req, input logic [31:0] addr,
                     input logic [63:0] ifid, input logic val, input logic [31:0] p);
    vec_t v;
    v.st = st; v.fl = fl; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
    v.req = req; v.addr = addr; v.ifid = ifid; v.val = val; v.pc = p;
    tv.push_back(v);
  endtask

  // Reference model: PC, IF/ID, an optional parked word, an optional
  // abandoned request still awaiting its response.
  logic [31:0] m_pc;
  logic [63:0] m_ifid;
  logic        m_val;
  logic        m_parked;
  logic [31:0] m_park_word;
  logic        m_drop;
  logic [31:0] m_drop_addr;

  function automatic logic        m_req();  return !m_parked; endfunction
  function automatic logic [31:0] m_addr(); return m_drop ? m_drop_addr : m_pc; endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_ifid = '0; m_val = 1'b0;
    m_parked = 1'b0; m_park_word = '0; m_drop = 1'b0; m_drop_addr = '0;
  endtask

  task automatic model_step(input logic st, input logic fl, input logic rd,
                            input logic [31:0] rpc, input logic rdy);
    logic [31:0] a;
    logic        waiting;
    a       = m_addr();
    waiting = m_req() && !rdy;
    if (rd) begin
      if (waiting) begin m_drop = 1'b1; m_drop_addr = a; end
      else m_drop = 1'b0;
      m_pc = {rpc[31:2], 2'b00};
      m_ifid = '0; m_val = 1'b0; m_parked = 1'b0;
    end else if (fl) begin
      m_ifid = '0; m_val = 1'b0; m_parked = 1'b0;
      if (m_drop && rdy) m_drop = 1'b0;
    end else if (m_drop) begin
      if (rdy) m_drop = 1'b0;
      if (!st) begin m_ifid = '0; m_val = 1'b0; end
    end else if (m_parked) begin
      if (!st) begin
        m_ifid = {m_pc + 32'd4, m_park_word}; m_val = 1'b1;
        m_pc = m_pc + 32'd4; m_parked = 1'b0;
      end
    end else if (st) begin
      if (rdy) begin m_parked = 1'b1; m_park_word = memword(a); end
    end else if (rdy) begin
      m_ifid = {m_pc + 32'd4, memword(a)}; m_val = 1'b1; m_pc = m_pc + 32'd4;
    end else begin
      m_ifid = '0; m_val = 1'b0;
    end
  endtask

  task automatic drive(input logic st, input logic fl, input logic rd,
                       input logic [31:0] rpc, input logic rdy);
    stall = st; flush = fl; redirect = rd; redirect_pc = rpc; imem_ready = rdy;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Directed vectors from reset (all stimulus fields, then expectations).
    //   st fl rd rpc           rdy req addr           ifid                                val pc
    add(0, 0, 0, 32'h0,        1,  1, 32'h0,         {32'h4, 32'h1},                     1, 32'h4);
    add(0, 0, 0, 32'h0,        1,  1, 32'h4,         {32'h8, 32'h2},                     1, 32'h8);
    add(0, 0, 0, 32'h0,        0,  1, 32'h8,         64'h0,                              0, 32'h8);
    add(0, 0, 0, 32'h0,        0,  1, 32'h8,         64'h0,                              0, 32'h8);
    add(0, 0, 0, 32'h0,        1,  1, 32'h8,         {32'hC, 32'h3},                     1, 32'hC);
    add(0, 0, 1, 32'h100,      0,  1, 32'hC,         64'h0,                              0, 32'h100);
    add(0, 0, 0, 32'h0,        0,  1, 32'hC,         64'h0,                              0, 32'h100);
    add(0, 0, 0, 32'h0,        1,  1, 32'hC,         64'h0,                              0, 32'h100);
    add(0, 0, 0, 32'h0,        1,  1, 32'h100,       {32'h104, 32'h41},                  1, 32'h104);
    add(1, 0, 0, 32'h0,        1,  1, 32'h104,       {32'h104, 32'h41},                  1, 32'h104);
    add(1, 0, 0, 32'h0,        0,  0, 32'h104,       {32'h104, 32'h41},                  1, 32'h104);
    add(1, 0, 0, 32'h0,        1,  0, 32'h104,       {32'h104, 32'h41},                  1, 32'h104);
    add(0, 0, 0, 32'h0,        0,  0, 32'h104,       {32'h108, 32'h42},                  1, 32'h108);
    add(0, 0, 0, 32'h0,        1,  1, 32'h108,       {32'h10C, 32'h43},                  1, 32'h10C);
    add(1, 1, 1, 32'h40,       1,  1, 32'h10C,       64'h0,                              0, 32'h40);
    add(0, 0, 0, 32'h0,        1,  1, 32'h40,        {32'h44, 32'h11},                   1, 32'h44);
    add(0, 0, 1, 32'hFFFFFFFF, 1,  1, 32'h44,        64'h0,                              0, 32'hFFFFFFFC);
    add(0, 0, 0, 32'h0,        1,  1, 32'hFFFFFFFC,  {32'h0, 32'h40000000},              1, 32'h0);
    add(0, 0, 0, 32'h0,        1,  1, 32'h0,         {32'h4, 32'h1},                     1, 32'h4);
    add(0, 1, 0, 32'h0,        1,  1, 32'h4,         64'h0,                              0, 32'h4);
    add(1, 0, 0, 32'h0,        1,  1, 32'h4,         64'h0,                              0, 32'h4);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_req",   {63'h0, imem_req},   64'h0);
    chk("reset_pc",    {32'h0, pc},         64'h0);
    chk("reset_ifid",  ifid_reg,            64'h0);
    chk("reset_valid", {63'h0, ifid_valid}, 64'h0);
    rst = 1'b0;

    foreach (tv[i]) begin
      drive(tv[i].st, tv[i].fl, tv[i].rd, tv[i].rpc, tv[i].rdy);
      #1;
      chk($sformatf("v%0d_req", i),  {63'h0, imem_req},  {63'h0, tv[i].req});
      chk($sformatf("v%0d_addr", i), {32'h0, imem_addr}, {32'h0, tv[i].addr});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ifid", i),  ifid_reg,            tv[i].ifid);
      chk($sformatf("v%0d_valid", i), {63'h0, ifid_valid}, {63'h0, tv[i].val});
      chk($sformatf("v%0d_pc", i),    {32'h0, pc},         {32'h0, tv[i].pc});
    end

    // Now in HOLD with a parked word: asynchronous reset mid-cycle.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    chk("hold_req_before_rst", {63'h0, imem_req}, 64'h0);
    #2 rst = 1'b1;
    #1;
    chk("rst_hold_pc",    {32'h0, pc},         64'h0);
    chk("rst_hold_ifid",  ifid_reg,            64'h0);
    chk("rst_hold_valid", {63'h0, ifid_valid}, 64'h0);
    chk("rst_hold_req",   {63'h0, imem_req},   64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    chk("post_rst_addr", {32'h0, imem_addr}, 64'h0);
    chk("post_rst_req",  {63'h0, imem_req},  64'h1);
    @(posedge clk);
    #1;
    chk("post_rst_ifid", ifid_reg, {32'h4, 32'h1});

    // Randomized run against the reference model.
    model_reset();
    model_step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      logic st, fl, rd, rdy;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 99) < 30);
      fl  = ($urandom_range(0, 99) < 8);
      rd  = ($urandom_range(0, 99) < 8);
      rdy = ($urandom_range(0, 99) < 65);
      rpc = $urandom;
      if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF8 | (rpc & 32'h7);
      drive(st, fl, rd, rpc, rdy);
      #1;
      chk($sformatf("r%0d_req", i),  {63'h0, imem_req},  {63'h0, m_req()});
      if (m_req())
        chk($sformatf("r%0d_addr", i), {32'h0, imem_addr}, {32'h0, m_addr()});
      model_step(st, fl, rd, rpc, rdy);
      @(posedge clk);
      #1;
      chk($sformatf("r%0d_ifid", i),  ifid_reg,            m_ifid);
      chk($sformatf("r%0d_valid", i), {63'h0, ifid_valid}, {63'h0, m_val});
      chk($sformatf("r%0d_pc", i),    {32'h0, pc},         {32'h0, m_pc});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
